// File: rtl/emd_delay_pkg.sv
// Shared types and defaults for the EMD sample delay line.
// Optional debug readout of the fill count: define DELAY_FILLCNT_EN.
package emd_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 6;
    localparam int DEPTH_DEF0 = 0;
    localparam int DEPTH_DEF1 = 8;
    localparam int DEPTH_DEF2 = 16;
    localparam int DEPTH_DEF3 = 32;

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
// Read data holds while rd_en is low.
module delay_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (rd_en)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/delay_ctrl.sv
// Delay-line sequencer for the EMD sifting path: fill, run, flush on type change.
// Define DELAY_FILLCNT_EN to expose the internal fill count on FILL_CNT.
module delay_ctrl
    import emd_delay_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH0 = DEPTH_DEF0,
    parameter int DEPTH1 = DEPTH_DEF1,
    parameter int DEPTH2 = DEPTH_DEF2,
    parameter int DEPTH3 = DEPTH_DEF3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [1:0]    DELAY_TYPE,
    input  logic [DW-1:0] XIN,
    input  logic          XIN_VALID,
    output logic          XIN_READY,
    output logic [DW-1:0] XOUT,
    output logic          XOUT_VALID,
`ifdef DELAY_FILLCNT_EN
    output logic [AW:0]   FILL_CNT,
`endif
    output logic          BUSY
);

    state_t        state, state_n;
    logic [AW-1:0] wp, wp_n;
    logic [AW:0]   fill_cnt, fill_n;
    logic [1:0]    type_q, type_n;
    logic          valid_q, valid_n;
    logic          use_ram, use_ram_n;
    logic [DW-1:0] pass_q, pass_n;
    logic          rd_en;
    logic          mismatch;
    logic          accept;
    logic [AW:0]   d_in, d_q;
    logic [AW:0]   dtab [4];
    logic [DW-1:0] ram_rdata;

    assign dtab[0] = (AW+1)'(DEPTH0);
    assign dtab[1] = (AW+1)'(DEPTH1);
    assign dtab[2] = (AW+1)'(DEPTH2);
    assign dtab[3] = (AW+1)'(DEPTH3);

    assign d_in     = dtab[DELAY_TYPE];
    assign d_q      = dtab[type_q];
    assign mismatch = (DELAY_TYPE != type_q);
    assign accept   = XIN_VALID && XIN_READY;

    always_comb begin
        state_n   = state;
        wp_n      = wp;
        fill_n    = fill_cnt;
        type_n    = type_q;
        valid_n   = 1'b0;
        use_ram_n = use_ram;
        pass_n    = pass_q;
        rd_en     = 1'b0;
        XIN_READY = 1'b0;
        unique case (state)
            ST_IDLE: begin
                XIN_READY = 1'b1;
                if (XIN_VALID) begin
                    type_n = DELAY_TYPE;
                    wp_n   = wp + 1'b1;
                    if (d_in == '0) begin
                        fill_n    = '0;
                        state_n   = ST_RUN;
                        valid_n   = 1'b1;
                        use_ram_n = 1'b0;
                        pass_n    = XIN;
                    end else begin
                        fill_n  = (AW+1)'(1);
                        state_n = (d_in == (AW+1)'(1)) ? ST_RUN : ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (mismatch) begin
                    state_n = ST_FLUSH;
                end else begin
                    XIN_READY = 1'b1;
                    if (XIN_VALID) begin
                        wp_n   = wp + 1'b1;
                        fill_n = fill_cnt + 1'b1;
                        if (fill_cnt + 1'b1 == d_q)
                            state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (mismatch) begin
                    state_n = ST_FLUSH;
                end else begin
                    XIN_READY = 1'b1;
                    if (XIN_VALID) begin
                        wp_n    = wp + 1'b1;
                        valid_n = 1'b1;
                        // zero depth bypasses the buffer entirely
                        if (d_q == '0) begin
                            use_ram_n = 1'b0;
                            pass_n    = XIN;
                        end else begin
                            use_ram_n = 1'b1;
                            rd_en     = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                wp_n    = '0;
                fill_n  = '0;
                type_n  = DELAY_TYPE;
                state_n = (d_in == '0) ? ST_RUN : ST_FILL;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            wp       <= '0;
            fill_cnt <= '0;
            type_q   <= '0;
            valid_q  <= 1'b0;
            use_ram  <= 1'b0;
            pass_q   <= '0;
        end else begin
            state    <= state_n;
            wp       <= wp_n;
            fill_cnt <= fill_n;
            type_q   <= type_n;
            valid_q  <= valid_n;
            use_ram  <= use_ram_n;
            pass_q   <= pass_n;
        end
    end

    delay_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk   (CLK),
        .we    (accept),
        .waddr (wp),
        .wdata (XIN),
        .rd_en (rd_en),
        .raddr (wp - d_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // both sources are registers; the mux only picks which one is current
    assign XOUT       = use_ram ? ram_rdata : pass_q;
    assign XOUT_VALID = valid_q;
    assign BUSY       = (state == ST_FILL) || (state == ST_FLUSH);

`ifdef DELAY_FILLCNT_EN
    assign FILL_CNT = fill_cnt;
`endif

endmodule
